mem_loader: RTL

- Write-side counterpart to the board's synchronous ROM/RAM read wrappers.
- Accepts a byte stream over a valid/ready handshake and writes each byte into the system memory bus at consecutive addresses, starting at a programmed base. Sources include the host download channel and the serial loader.
- Holds the 6502 halted while a load is in progress.
- Reports progress and an 8-bit additive checksum of the bytes it wrote.

---
 rtl/mem_loader_pkg.sv | 20 ++
 rtl/mem_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream memory loader.
// Includes the Apple-1 address map used by instantiators.
package mem_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 16;

    // Apple-1 load targets
    localparam logic [15:0] RAM_BASE     = 16'h0000;
    localparam logic [15:0] BASIC_BASE   = 16'hE000;
    localparam logic [15:0] MONITOR_BASE = 16'hFF00;

endpackage

// File: rtl/mem_loader.sv
// Streams bytes from a valid/ready source into consecutive memory
// addresses, halting the CPU and accumulating an 8-bit checksum.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int HALT_CPU   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_dout,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_halt,
    output logic [ADDR_WIDTH-1:0] byte_count,
    output logic [7:0]            checksum
);

    localparam logic HALT = (HALT_CPU != 0);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   len_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic [ADDR_WIDTH-1:0]   count_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [7:0]              mem_dout_q;
    logic [7:0]              sum_q;
    logic [7:0]              sum_d;
    logic                    in_ready_q;
    logic                    wr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    halt_q;

    // Next count, running sum and target address of the pending byte
    always_comb begin
        count_d = count_q + 1'b1;
        sum_d   = sum_q + mem_dout_q;
        addr_d  = base_q + count_q;
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= length;
                        count_q <= '0;
                        sum_q   <= '0;
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RECV;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            halt_q     <= HALT;
                        end
                    end
                end
                S_RECV: begin
                    if (in_valid && in_ready_q) begin
                        mem_dout_q <= in_data;
                        mem_addr_q <= addr_d;
                        in_ready_q <= 1'b0;
                        wr_q       <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    count_q <= count_d;
                    sum_q   <= sum_d;
                    if (count_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        halt_q  <= 1'b0;
                    end else begin
                        state_q    <= S_RECV;
                        in_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dout   = mem_dout_q;
    assign mem_cs     = wr_q;
    assign mem_we     = wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_halt   = halt_q;
    assign byte_count = count_q;
    assign checksum   = sum_q;

endmodule
